sa_12: RTL and testbench
========================

// Module: sa_12
// PURPOSE
//  Switch allocator + output stage for router 12 (ports N,W,S,L; no E). Sits directly downstream of the
//  per-port route-compute stages: consumes each input's flit and one-hot direction, runs round-robin
//  arbitration per output port, and returns the consume strobe (rc_ready_X) to the route-compute stage.
//  Each output port has a registered valid/ready stage that feeds the link or local sink.
// PARAMETERS
//  DATASIZE  40  flit width in bits
// PORTS
//  sa_clk              in   1         clock; all state changes on rising edge
//  rst                 in   1         synchronous reset, active-high
//  X_data_in           in   DATASIZE  flit from route-compute stage X, X in {N,W,S,L}
//  X_dir_in            in   4         one-hot requested output {L,S,W,N}=bits[3:0]; 4'b0000 = no request
//  rc_ready_X          out  1         input X granted this cycle; route-compute stage advances its flit
//  X_data_out          out  DATASIZE  registered flit on output port X
//  X_valid_out         out  1         X_data_out holds a flit
//  X_ready_in          in   1         downstream of output X accepts this cycle
//  dir_err             out  1         sticky: some X_dir_in had more than one bit set
// BEHAVIOUR
//  Index order: N=0, W=1, S=2, L=3. Applies to direction bits, inputs, outputs and the pointer.
//  Request: input i requests output o when dir_in_i == (1<<o). Non-one-hot, non-zero dir counts as no request.
//   Such a cycle sets dir_err; dir_err clears only on rst.
//  Output register o is free when !valid_out[o] || ready_in[o] (pass-through on pop allowed).
//  Arbitration per output o, combinational, every cycle:
//   - Among requesting inputs, grant the first at or after ptr[o], searching upward mod 4.
//   - Grant only if register o is free.
//   - Inputs request at most one output each, so at most one grant per input per cycle.
//  Grant effects:
//   - rc_ready_i = 1 in the same cycle, combinational from regs and inputs.
//   - Next edge: data_out[o] <= data_in_i, valid_out[o] <= 1, ptr[o] <= (i+1) mod 4.
//  No grant to o:
//   - If ready_in[o] is high, valid_out[o] <= 0; data_out[o] holds its last value.
//   - ptr[o] holds.
//  Stall: with valid_out[o]=1 and ready_in[o]=0, data_out/valid_out stay stable. No grants to o.
//   Requesters see rc_ready=0 and keep presenting.
//  Latency: 1 cycle from grant to valid_out. Throughput: 1 flit/cycle per output under continuous ready_in.
//  Fairness: with N contenders held continuously, each is served once within every 4 grants of that output.
//  U-turn (input i to output i) is legal and handled like any other request.
//  Simultaneous pop and grant on o: the new flit replaces the old with no bubble; valid_out stays 1.
//  Reset (rst=1 at edge): every valid_out=0, data_out=0, ptr=0 (N first), dir_err=0.
//   During a reset cycle rc_ready_X is forced 0.
//   Reset mid-stall drops any held flit; upstream keeps its own flit since rc_ready was 0.
//  Multi-flit packets and output locking are out of scope; every flit is arbitrated independently.
// TESTING
//  1 Reset: hold rst 2 cycles with all dirs=4'b0001.
//    -> all valid_out=0, data_out=0, rc_ready_*=0, dir_err=0.
//  2 Single path: W_dir_in=4'b0100, W_data_in=40'hA5, S_ready_in=1.
//    -> rc_ready_W=1 in the same cycle; next cycle S_valid_out=1, S_data_out=40'hA5.
//  3 Round robin: N,W,L all dir=4'b1000 (to L), L_ready_in=1, 8 cycles from reset.
//    -> grant order N,W,L,N,W,L,N,W.
//  4 Backpressure: S_ready_in=0 with S_valid_out=1, N requests S for 3 cycles.
//    -> S_data_out stable, rc_ready_N=0; S_ready_in=1 -> rc_ready_N=1 that cycle, N flit out next cycle.
//  5 Error: S_dir_in=4'b0011 for 1 cycle.
//    -> no grant to S, dir_err=1 and stays 1 until rst.
//  6 Parallel: N->S, S->N, W->L, L->W together, all ready.
//    -> all four rc_ready=1 in one cycle; all four outputs valid next cycle.

Source files
------------

// File: rtl/sa_12.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sa_12                                                           |
// | Purpose  : Round-robin switch allocator and registered output stage for    |
// |            router 12 (ports N, W, S, L).                                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sa_12 #(
  parameter int DATASIZE = 40
) (
  input  logic                sa_clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] N_data_in,
  input  logic [DATASIZE-1:0] W_data_in,
  input  logic [DATASIZE-1:0] S_data_in,
  input  logic [DATASIZE-1:0] L_data_in,
  input  logic [3:0]          N_dir_in,
  input  logic [3:0]          W_dir_in,
  input  logic [3:0]          S_dir_in,
  input  logic [3:0]          L_dir_in,
  output logic                rc_ready_N,
  output logic                rc_ready_W,
  output logic                rc_ready_S,
  output logic                rc_ready_L,
  output logic [DATASIZE-1:0] N_data_out,
  output logic [DATASIZE-1:0] W_data_out,
  output logic [DATASIZE-1:0] S_data_out,
  output logic [DATASIZE-1:0] L_data_out,
  output logic                N_valid_out,
  output logic                W_valid_out,
  output logic                S_valid_out,
  output logic                L_valid_out,
  input  logic                N_ready_in,
  input  logic                W_ready_in,
  input  logic                S_ready_in,
  input  logic                L_ready_in,
  output logic                dir_err
);

  localparam int NP = 4;

  logic [DATASIZE-1:0] w_din [NP];
  logic [3:0]          w_dir [NP];
  logic [NP-1:0]       w_rdy;

  logic [DATASIZE-1:0] data_q [NP];
  logic [DATASIZE-1:0] data_d [NP];
  logic [NP-1:0]       valid_q, valid_d;
  logic [1:0]          ptr_q [NP];
  logic [1:0]          ptr_d [NP];
  logic                dir_err_q, dir_err_d;

  logic [NP-1:0]       w_gnt_vld;
  logic [1:0]          w_gnt_src [NP];
  logic [NP-1:0]       w_rc;

  assign w_din[0] = N_data_in;
  assign w_din[1] = W_data_in;
  assign w_din[2] = S_data_in;
  assign w_din[3] = L_data_in;
  assign w_dir[0] = N_dir_in;
  assign w_dir[1] = W_dir_in;
  assign w_dir[2] = S_dir_in;
  assign w_dir[3] = L_dir_in;
  assign w_rdy    = {L_ready_in, S_ready_in, W_ready_in, N_ready_in};

  // Per output: first requester at or after the pointer, gated by a free register.
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      w_gnt_vld[o] = 1'b0;
      w_gnt_src[o] = 2'd0;
      for (int k = 0; k < NP; k++) begin
        if (!w_gnt_vld[o] && (w_dir[ptr_q[o] + 2'(k)] == (4'b0001 << o))) begin
          w_gnt_vld[o] = 1'b1;
          w_gnt_src[o] = ptr_q[o] + 2'(k);
        end
      end
      w_gnt_vld[o] = w_gnt_vld[o] && (!valid_q[o] || w_rdy[o]) && !rst;
    end
  end

  always_comb begin
    w_rc = '0;
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        if (w_gnt_vld[o] && (w_gnt_src[o] == 2'(i))) begin
          w_rc[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
    dir_err_d = dir_err_q;
    for (int o = 0; o < NP; o++) begin
      if (w_gnt_vld[o]) begin
        data_d[o]  = w_din[w_gnt_src[o]];
        valid_d[o] = 1'b1;
        ptr_d[o]   = w_gnt_src[o] + 2'd1;
      end else if (w_rdy[o]) begin
        valid_d[o] = 1'b0;
      end
    end
    // More than one direction bit set is a malformed request.
    for (int i = 0; i < NP; i++) begin
      if ((w_dir[i] != 4'd0) && ((w_dir[i] & (w_dir[i] - 4'd1)) != 4'd0)) begin
        dir_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sa_clk) begin
    if (rst) begin
      for (int o = 0; o < NP; o++) begin
        data_q[o] <= '0;
        ptr_q[o]  <= 2'd0;
      end
      valid_q   <= '0;
      dir_err_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      ptr_q     <= ptr_d;
      dir_err_q <= dir_err_d;
    end
  end

  assign rc_ready_N  = w_rc[0];
  assign rc_ready_W  = w_rc[1];
  assign rc_ready_S  = w_rc[2];
  assign rc_ready_L  = w_rc[3];
  assign N_data_out  = data_q[0];
  assign W_data_out  = data_q[1];
  assign S_data_out  = data_q[2];
  assign L_data_out  = data_q[3];
  assign N_valid_out = valid_q[0];
  assign W_valid_out = valid_q[1];
  assign S_valid_out = valid_q[2];
  assign L_valid_out = valid_q[3];
  assign dir_err     = dir_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sa_12.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sa_12                                                        |
// | Purpose  : Directed vector table plus hand sequences for sa_12.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sa_12;

  localparam int DATASIZE = 40;

  logic                sa_clk = 1'b0;
  logic                rst;
  logic [DATASIZE-1:0] din [4];
  logic [3:0]          dir [4];
  logic [3:0]          rdy;
  logic [DATASIZE-1:0] dout [4];
  logic [3:0]          vout;
  logic [3:0]          rc;
  logic                dir_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 sa_clk = ~sa_clk;

  sa_12 #(.DATASIZE(DATASIZE)) dut (
    .sa_clk(sa_clk), .rst(rst),
    .N_data_in(din[0]), .W_data_in(din[1]), .S_data_in(din[2]), .L_data_in(din[3]),
    .N_dir_in(dir[0]), .W_dir_in(dir[1]), .S_dir_in(dir[2]), .L_dir_in(dir[3]),
    .rc_ready_N(rc[0]), .rc_ready_W(rc[1]), .rc_ready_S(rc[2]), .rc_ready_L(rc[3]),
    .N_data_out(dout[0]), .W_data_out(dout[1]), .S_data_out(dout[2]), .L_data_out(dout[3]),
    .N_valid_out(vout[0]), .W_valid_out(vout[1]), .S_valid_out(vout[2]), .L_valid_out(vout[3]),
    .N_ready_in(rdy[0]), .W_ready_in(rdy[1]), .S_ready_in(rdy[2]), .L_ready_in(rdy[3]),
    .dir_err(dir_err)
  );

  typedef struct {
    logic [15:0] dirs;   // {L,S,W,N} direction nibbles
    logic [3:0]  ready;
    logic [3:0]  exp_rc;
    logic [3:0]  exp_vld;
    logic [3:0]  dmask;  // outputs whose data is checked after the edge
    logic [7:0]  src;    // 2-bit source input per output
    logic        exp_err;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sa_clk);
    #1;
  endtask

  function automatic logic [DATASIZE-1:0] pat(input int v, input int i);
    return DATASIZE'(64'hD0D0_0000 | (v << 4) | i);
  endfunction

  task automatic idle();
    for (int i = 0; i < 4; i++) begin
      dir[i] = 4'd0;
      din[i] = '0;
    end
    rdy = 4'hF;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int order [8];
    order = '{0, 1, 3, 0, 1, 3, 0, 1};

    //            dirs      ready  rc     vld    dmask  src    err
    tbl[0]  = '{16'h0000, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0};
    tbl[1]  = '{16'h0040, 4'hF, 4'h2, 4'h4, 4'h4, 8'h10, 1'b0};
    tbl[2]  = '{16'h2184, 4'hF, 4'hF, 4'hF, 4'hF, 8'h4E, 1'b0};
    tbl[3]  = '{16'h8088, 4'hF, 4'h8, 4'h8, 4'h8, 8'hC0, 1'b0};
    tbl[4]  = '{16'h8088, 4'hF, 4'h1, 4'h8, 4'h8, 8'h00, 1'b0};
    tbl[5]  = '{16'h8088, 4'hF, 4'h2, 4'h8, 4'h8, 8'h40, 1'b0};
    tbl[6]  = '{16'h8088, 4'h7, 4'h0, 4'h8, 4'h0, 8'h00, 1'b0};
    tbl[7]  = '{16'h8088, 4'hF, 4'h8, 4'h8, 4'h8, 8'hC0, 1'b0};
    tbl[8]  = '{16'h0300, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 1'b1};
    tbl[9]  = '{16'h0001, 4'hF, 4'h1, 4'h1, 4'h1, 8'h00, 1'b1};
    tbl[10] = '{16'h0000, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 1'b1};

    // Reset with every input requesting N: nothing may be granted.
    idle();
    for (int i = 0; i < 4; i++) dir[i] = 4'b0001;
    rst = 1'b1;
    step();
    #2;
    chk("rst_rc", 64'(rc), 64'h0);
    step();
    chk("rst_vld", 64'(vout), 64'h0);
    chk("rst_err", 64'(dir_err), 64'h0);
    for (int o = 0; o < 4; o++) chk($sformatf("rst_data%0d", o), 64'(dout[o]), 64'h0);
    rst = 1'b0;
    idle();

    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < 4; i++) begin
        dir[i] = tbl[v].dirs[4*i +: 4];
        din[i] = pat(v, i);
      end
      rdy = tbl[v].ready;
      #2;
      chk($sformatf("v%0d_rc", v), 64'(rc), 64'(tbl[v].exp_rc));
      step();
      chk($sformatf("v%0d_vld", v), 64'(vout), 64'(tbl[v].exp_vld));
      chk($sformatf("v%0d_err", v), 64'(dir_err), 64'(tbl[v].exp_err));
      for (int o = 0; o < 4; o++) begin
        if (tbl[v].dmask[o]) begin
          chk($sformatf("v%0d_data%0d", v, o), 64'(dout[o]),
              64'(pat(v, int'(tbl[v].src[2*o +: 2]))));
        end
      end
    end

    // Reset clears the sticky error; then round robin N,W,L contending for L.
    do_reset();
    chk("err_cleared", 64'(dir_err), 64'h0);
    dir[0] = 4'b1000;
    dir[1] = 4'b1000;
    dir[3] = 4'b1000;
    for (int c = 0; c < 8; c++) begin
      #2;
      chk($sformatf("rr%0d", c), 64'(rc), 64'(4'b0001 << order[c]));
      step();
    end

    // Single path W->S, then backpressure on S with N waiting.
    do_reset();
    dir[1] = 4'b0100;
    din[1] = 40'hA5;
    #2;
    chk("path_rcW", 64'(rc), 64'h2);
    step();
    chk("path_vld", 64'(vout[2]), 64'h1);
    chk("path_data", 64'(S_data()), 64'hA5);
    dir[1] = 4'd0;
    rdy[2] = 1'b0;
    dir[0] = 4'b0100;
    din[0] = 40'h222;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("bp%0d_rc", c), 64'(rc), 64'h0);
      step();
      chk($sformatf("bp%0d_data", c), 64'(S_data()), 64'hA5);
      chk($sformatf("bp%0d_vld", c), 64'(vout[2]), 64'h1);
    end
    rdy[2] = 1'b1;
    #2;
    chk("bp_rel_rc", 64'(rc), 64'h1);
    step();
    chk("bp_rel_vld", 64'(vout[2]), 64'h1);
    chk("bp_rel_data", 64'(S_data()), 64'h222);

    // Reset while S is stalled drops the held flit.
    rdy[2] = 1'b0;
    din[0] = 40'h333;
    rst = 1'b1;
    #2;
    chk("rst_stall_rc", 64'(rc), 64'h0);
    step();
    rst = 1'b0;
    chk("rst_stall_vld", 64'(vout[2]), 64'h0);
    chk("rst_stall_data", 64'(S_data()), 64'h0);

    // Error sticks across idle cycles until reset.
    idle();
    dir[2] = 4'b0011;
    #2;
    chk("err_rc", 64'(rc), 64'h0);
    step();
    idle();
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("err_sticky%0d", c), 64'(dir_err), 64'h1);
    end
    chk("err_no_vld", 64'(vout), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  function automatic logic [DATASIZE-1:0] S_data();
    return dout[2];
  endfunction

endmodule
`default_nettype wire
